// File: rtl/e203_subsys_clint_arb_pkg.sv
// Shared constants and types for the CLINT two-master ICB arbiter.
package e203_subsys_clint_arb_pkg;

   // Default number of commands that may be in flight to the CLINT.
   localparam int unsigned E203_CLINT_ARB_OUTS_DEPTH = 2;
   // Width of the grant ID stored per outstanding command.
   localparam int unsigned E203_CLINT_ARB_ID_W = 1;

   // Master identities; the value doubles as the grant ID.
   typedef enum logic {
      MstLsu = 1'b0,
      MstDbg = 1'b1
   } arb_mst_e;

   // Pick the winner from the current valids; the round-robin pointer only matters on a tie.
   // With nobody requesting, master 0 is selected so the muxes have a stable default.
   function automatic arb_mst_e rr_pick(input logic v0, input logic v1, input arb_mst_e ptr);
      arb_mst_e win;
      if (v0 && v1) begin
         win = ptr;
      end else if (v1) begin
         win = MstDbg;
      end else begin
         win = MstLsu;
      end
      return win;
   endfunction

endpackage

// File: rtl/e203_subsys_clint_arb_fifo.sv
// Small shift-register FIFO holding the grant ID of every outstanding command.
// Entry 0 is always the head, so the head ID is a plain register output.
module e203_subsys_clint_arb_fifo
   import e203_subsys_clint_arb_pkg::*;
#(
   parameter int unsigned DP        = E203_CLINT_ARB_OUTS_DEPTH,
   parameter int unsigned DW        = E203_CLINT_ARB_ID_W,
   // 0: i_rdy depends only on the stored count (no path from o_rdy).
   // 1: a pop in the same cycle frees a slot for a push while full.
   parameter bit          CUT_READY = 1'b0,
   // 1: force o_dat to zero while empty.
   parameter bit          MSKO      = 1'b0,
   localparam int unsigned CW       = $clog2(DP + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_vld,
   output logic          i_rdy,
   input  logic [DW-1:0] i_dat,
   output logic          o_vld,
   input  logic          o_rdy,
   output logic [DW-1:0] o_dat,
   output logic [CW-1:0] cnt_o
);

   logic [DW-1:0] mem_q [DP];
   logic [DW-1:0] mem_d [DP];
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;
   logic          full;
   logic          empty;
   logic          push;
   logic          pop;
   int            wr_idx;

   // Status, handshakes and head output.
   always_comb begin
      full   = (cnt_q == CW'(DP));
      empty  = (cnt_q == '0);
      o_vld  = ~empty;
      pop    = o_vld & o_rdy;
      i_rdy  = ~full | (CUT_READY & pop);
      push   = i_vld & i_rdy;
      o_dat  = (MSKO && empty) ? '0 : mem_q[0];
      cnt_o  = cnt_q;
   end

   // Next contents: shift toward the head on pop, then write the new entry behind the last one.
   always_comb begin
      mem_d  = mem_q;
      cnt_d  = cnt_q;
      wr_idx = int'(cnt_q) - (pop ? 1 : 0);
      if (pop) begin
         for (int i = 0; i < int'(DP) - 1; i++) begin
            mem_d[i] = mem_q[i + 1];
         end
         mem_d[DP-1] = '0;
      end
      if (push) begin
         for (int i = 0; i < int'(DP); i++) begin
            if (i == wr_idx) begin
               mem_d[i] = i_dat;
            end
         end
      end
      unique case ({push, pop})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   // Storage and occupancy count, cleared by synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
         for (int i = 0; i < int'(DP); i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         cnt_q <= cnt_d;
         mem_q <= mem_d;
      end
   end

endmodule

// File: rtl/e203_subsys_clint_arb.sv
// Round-robin arbiter letting the LSU (m0) and the debug/system bus (m1) share the CLINT ICB port.
// Commands and responses pass through combinationally; a grant-ID FIFO routes responses in order.
module e203_subsys_clint_arb
   import e203_subsys_clint_arb_pkg::*;
#(
   parameter int unsigned AW         = 32,
   parameter int unsigned DW         = 32,
   parameter int unsigned OUTS_DEPTH = E203_CLINT_ARB_OUTS_DEPTH
) (
   input  logic            clk,
   input  logic            rst,

   input  logic            m0_icb_cmd_valid,
   output logic            m0_icb_cmd_ready,
   input  logic [AW-1:0]   m0_icb_cmd_addr,
   input  logic            m0_icb_cmd_read,
   input  logic [DW-1:0]   m0_icb_cmd_wdata,
   input  logic [DW/8-1:0] m0_icb_cmd_wmask,
   output logic            m0_icb_rsp_valid,
   input  logic            m0_icb_rsp_ready,
   output logic            m0_icb_rsp_err,
   output logic [DW-1:0]   m0_icb_rsp_rdata,

   input  logic            m1_icb_cmd_valid,
   output logic            m1_icb_cmd_ready,
   input  logic [AW-1:0]   m1_icb_cmd_addr,
   input  logic            m1_icb_cmd_read,
   input  logic [DW-1:0]   m1_icb_cmd_wdata,
   input  logic [DW/8-1:0] m1_icb_cmd_wmask,
   output logic            m1_icb_rsp_valid,
   input  logic            m1_icb_rsp_ready,
   output logic            m1_icb_rsp_err,
   output logic [DW-1:0]   m1_icb_rsp_rdata,

   output logic            sl_icb_cmd_valid,
   input  logic            sl_icb_cmd_ready,
   output logic [AW-1:0]   sl_icb_cmd_addr,
   output logic            sl_icb_cmd_read,
   output logic [DW-1:0]   sl_icb_cmd_wdata,
   output logic [DW/8-1:0] sl_icb_cmd_wmask,
   input  logic            sl_icb_rsp_valid,
   output logic            sl_icb_rsp_ready,
   input  logic            sl_icb_rsp_err,
   input  logic [DW-1:0]   sl_icb_rsp_rdata,

   output logic            arb_busy
);

   localparam int unsigned CW = $clog2(OUTS_DEPTH + 1);

   if (OUTS_DEPTH < 1 || OUTS_DEPTH > 4) begin : g_bad_depth
      $error("OUTS_DEPTH must be in 1..4");
   end

   arb_mst_e                        rr_ptr_q;
   arb_mst_e                        rr_ptr_d;
   arb_mst_e                        winner_id;
   arb_mst_e                        head_id;
   logic                            winner_valid;
   logic                            cmd_rdy_gated;
   logic                            cmd_hsk;
   logic                            fifo_push_rdy;
   logic                            fifo_nempty;
   logic                            head_rsp_ready;
   logic                            rsp_hsk;
   logic [E203_CLINT_ARB_ID_W-1:0]  fifo_head;
   logic [CW-1:0]                   outs_cnt;

   // Command arbitration, gating and field mux.
   always_comb begin
      winner_id     = rr_pick(m0_icb_cmd_valid, m1_icb_cmd_valid, rr_ptr_q);
      winner_valid  = m0_icb_cmd_valid | m1_icb_cmd_valid;
      // fifo_push_rdy is ~full only, so there is no ready-to-ready path through the FIFO.
      sl_icb_cmd_valid = winner_valid & fifo_push_rdy & ~rst;
      cmd_rdy_gated    = sl_icb_cmd_ready & fifo_push_rdy & ~rst;
      m0_icb_cmd_ready = cmd_rdy_gated & (winner_id == MstLsu);
      m1_icb_cmd_ready = cmd_rdy_gated & (winner_id == MstDbg);
      cmd_hsk          = sl_icb_cmd_valid & sl_icb_cmd_ready;
      if (winner_id == MstDbg) begin
         sl_icb_cmd_addr  = m1_icb_cmd_addr;
         sl_icb_cmd_read  = m1_icb_cmd_read;
         sl_icb_cmd_wdata = m1_icb_cmd_wdata;
         sl_icb_cmd_wmask = m1_icb_cmd_wmask;
      end else begin
         sl_icb_cmd_addr  = m0_icb_cmd_addr;
         sl_icb_cmd_read  = m0_icb_cmd_read;
         sl_icb_cmd_wdata = m0_icb_cmd_wdata;
         sl_icb_cmd_wmask = m0_icb_cmd_wmask;
      end
   end

   // Response routing by the FIFO head ID; data fans out, only valid is steered.
   always_comb begin
      head_id          = arb_mst_e'(fifo_head);
      head_rsp_ready   = (head_id == MstDbg) ? m1_icb_rsp_ready : m0_icb_rsp_ready;
      m0_icb_rsp_valid = sl_icb_rsp_valid & fifo_nempty & (head_id == MstLsu) & ~rst;
      m1_icb_rsp_valid = sl_icb_rsp_valid & fifo_nempty & (head_id == MstDbg) & ~rst;
      sl_icb_rsp_ready = head_rsp_ready & fifo_nempty & ~rst;
      rsp_hsk          = sl_icb_rsp_valid & sl_icb_rsp_ready;
      m0_icb_rsp_err   = sl_icb_rsp_err;
      m1_icb_rsp_err   = sl_icb_rsp_err;
      m0_icb_rsp_rdata = sl_icb_rsp_rdata;
      m1_icb_rsp_rdata = sl_icb_rsp_rdata;
      arb_busy         = (outs_cnt != '0);
   end

   // Priority passes to the other master after every accepted command.
   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (cmd_hsk) begin
         rr_ptr_d = arb_mst_e'(~winner_id);
      end
   end

   // Round-robin pointer register.
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr_q <= MstLsu;
      end else begin
         rr_ptr_q <= rr_ptr_d;
      end
   end

   // A response with nothing outstanding is a CLINT protocol violation.
   always_ff @(posedge clk) begin
      if (!rst) begin
         a_no_orphan_rsp : assert (!(sl_icb_rsp_valid && !fifo_nempty));
      end
   end

   e203_subsys_clint_arb_fifo #(
      .DP        (OUTS_DEPTH),
      .DW        (E203_CLINT_ARB_ID_W),
      .CUT_READY (1'b0),
      .MSKO      (1'b0)
   ) u_clint_arb_id_fifo (
      .clk   (clk),
      .rst   (rst),
      .i_vld (cmd_hsk),
      .i_rdy (fifo_push_rdy),
      .i_dat (winner_id),
      .o_vld (fifo_nempty),
      .o_rdy (rsp_hsk),
      .o_dat (fifo_head),
      .cnt_o (outs_cnt)
   );

endmodule

// File: tb/tb_e203_subsys_clint_arb.sv
// Directed bench for the CLINT two-master arbiter (AW=DW=32, OUTS_DEPTH=2).
module tb_e203_subsys_clint_arb;

   localparam logic [31:0] M0_ADDR = 32'h0200_0000;
   localparam logic [31:0] M1_ADDR = 32'h0200_BFF8;

   logic        clk = 1'b0;
   logic        rst;
   logic        m0_icb_cmd_valid, m0_icb_cmd_ready, m0_icb_cmd_read;
   logic [31:0] m0_icb_cmd_addr, m0_icb_cmd_wdata;
   logic [3:0]  m0_icb_cmd_wmask;
   logic        m0_icb_rsp_valid, m0_icb_rsp_ready, m0_icb_rsp_err;
   logic [31:0] m0_icb_rsp_rdata;
   logic        m1_icb_cmd_valid, m1_icb_cmd_ready, m1_icb_cmd_read;
   logic [31:0] m1_icb_cmd_addr, m1_icb_cmd_wdata;
   logic [3:0]  m1_icb_cmd_wmask;
   logic        m1_icb_rsp_valid, m1_icb_rsp_ready, m1_icb_rsp_err;
   logic [31:0] m1_icb_rsp_rdata;
   logic        sl_icb_cmd_valid, sl_icb_cmd_ready, sl_icb_cmd_read;
   logic [31:0] sl_icb_cmd_addr, sl_icb_cmd_wdata;
   logic [3:0]  sl_icb_cmd_wmask;
   logic        sl_icb_rsp_valid, sl_icb_rsp_ready, sl_icb_rsp_err;
   logic [31:0] sl_icb_rsp_rdata;
   logic        arb_busy;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   e203_subsys_clint_arb #(
      .AW         (32),
      .DW         (32),
      .OUTS_DEPTH (2)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .m0_icb_cmd_valid (m0_icb_cmd_valid),
      .m0_icb_cmd_ready (m0_icb_cmd_ready),
      .m0_icb_cmd_addr  (m0_icb_cmd_addr),
      .m0_icb_cmd_read  (m0_icb_cmd_read),
      .m0_icb_cmd_wdata (m0_icb_cmd_wdata),
      .m0_icb_cmd_wmask (m0_icb_cmd_wmask),
      .m0_icb_rsp_valid (m0_icb_rsp_valid),
      .m0_icb_rsp_ready (m0_icb_rsp_ready),
      .m0_icb_rsp_err   (m0_icb_rsp_err),
      .m0_icb_rsp_rdata (m0_icb_rsp_rdata),
      .m1_icb_cmd_valid (m1_icb_cmd_valid),
      .m1_icb_cmd_ready (m1_icb_cmd_ready),
      .m1_icb_cmd_addr  (m1_icb_cmd_addr),
      .m1_icb_cmd_read  (m1_icb_cmd_read),
      .m1_icb_cmd_wdata (m1_icb_cmd_wdata),
      .m1_icb_cmd_wmask (m1_icb_cmd_wmask),
      .m1_icb_rsp_valid (m1_icb_rsp_valid),
      .m1_icb_rsp_ready (m1_icb_rsp_ready),
      .m1_icb_rsp_err   (m1_icb_rsp_err),
      .m1_icb_rsp_rdata (m1_icb_rsp_rdata),
      .sl_icb_cmd_valid (sl_icb_cmd_valid),
      .sl_icb_cmd_ready (sl_icb_cmd_ready),
      .sl_icb_cmd_addr  (sl_icb_cmd_addr),
      .sl_icb_cmd_read  (sl_icb_cmd_read),
      .sl_icb_cmd_wdata (sl_icb_cmd_wdata),
      .sl_icb_cmd_wmask (sl_icb_cmd_wmask),
      .sl_icb_rsp_valid (sl_icb_rsp_valid),
      .sl_icb_rsp_ready (sl_icb_rsp_ready),
      .sl_icb_rsp_err   (sl_icb_rsp_err),
      .sl_icb_rsp_rdata (sl_icb_rsp_rdata),
      .arb_busy         (arb_busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance one clock; inputs are then driven 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [1:0] exp_g;
      logic [1:0] exp_r;

      rst              = 1'b1;
      m0_icb_cmd_valid = 1'b1;
      m0_icb_cmd_addr  = M0_ADDR;
      m0_icb_cmd_read  = 1'b1;
      m0_icb_cmd_wdata = 32'h0000_00AA;
      m0_icb_cmd_wmask = 4'hF;
      m0_icb_rsp_ready = 1'b1;
      m1_icb_cmd_valid = 1'b1;
      m1_icb_cmd_addr  = M1_ADDR;
      m1_icb_cmd_read  = 1'b1;
      m1_icb_cmd_wdata = 32'h0000_00BB;
      m1_icb_cmd_wmask = 4'h3;
      m1_icb_rsp_ready = 1'b1;
      sl_icb_cmd_ready = 1'b1;
      sl_icb_rsp_valid = 1'b0;
      sl_icb_rsp_err   = 1'b0;
      sl_icb_rsp_rdata = 32'h0;

      // ---- reset: outputs gated, data follows master 0
      #1;
      chk("rst_sl_cmd_valid", {31'b0, sl_icb_cmd_valid}, 32'h0);
      chk("rst_cmd_ready", {30'b0, m1_icb_cmd_ready, m0_icb_cmd_ready}, 32'h0);
      chk("rst_rsp", {29'b0, m1_icb_rsp_valid, m0_icb_rsp_valid, sl_icb_rsp_ready}, 32'h0);
      chk("rst_addr_mux", sl_icb_cmd_addr, M0_ADDR);
      tick();
      tick();
      rst = 1'b0;
      #1;
      chk("post_rst_busy", {31'b0, arb_busy}, 32'h0);

      // ---- contention: grants alternate 0,1,0,1,0,1, 1-cycle responses
      for (int i = 0; i <= 6; i++) begin
         m0_icb_cmd_valid = (i < 6);
         m1_icb_cmd_valid = (i < 6);
         sl_icb_rsp_valid = (i > 0);
         sl_icb_rsp_rdata = 32'h0000_00A0 + 32'(i);
         #1;
         if (i < 6) begin
            exp_g = (i % 2 == 1) ? 2'b10 : 2'b01;
            chk("cont_grant", {30'b0, m1_icb_cmd_ready, m0_icb_cmd_ready}, {30'b0, exp_g});
            chk("cont_addr", sl_icb_cmd_addr, (i % 2 == 1) ? M1_ADDR : M0_ADDR);
         end
         if (i > 0) begin
            exp_r = ((i - 1) % 2 == 1) ? 2'b10 : 2'b01;
            chk("cont_rsp_route", {30'b0, m1_icb_rsp_valid, m0_icb_rsp_valid}, {30'b0, exp_r});
            chk("cont_rdata", (exp_r[1] ? m1_icb_rsp_rdata : m0_icb_rsp_rdata),
                32'h0000_00A0 + 32'(i));
         end
         tick();
      end
      sl_icb_rsp_valid = 1'b0;
      #1;
      chk("cont_idle_busy", {31'b0, arb_busy}, 32'h0);

      // ---- single master write
      m0_icb_cmd_valid = 1'b1;
      m0_icb_cmd_addr  = 32'h0200_4000;
      m0_icb_cmd_read  = 1'b0;
      m0_icb_cmd_wdata = 32'h1234_5678;
      m0_icb_cmd_wmask = 4'hF;
      #1;
      chk("single_valid", {31'b0, sl_icb_cmd_valid}, 32'h1);
      chk("single_addr", sl_icb_cmd_addr, 32'h0200_4000);
      chk("single_wdata", sl_icb_cmd_wdata, 32'h1234_5678);
      chk("single_wmask_read", {27'b0, sl_icb_cmd_read, sl_icb_cmd_wmask}, 32'h0000_000F);
      chk("single_ready", {30'b0, m1_icb_cmd_ready, m0_icb_cmd_ready}, 32'h1);
      tick();
      m0_icb_cmd_valid = 1'b0;
      m0_icb_cmd_addr  = M0_ADDR;
      sl_icb_rsp_valid = 1'b1;
      sl_icb_rsp_err   = 1'b0;
      sl_icb_rsp_rdata = 32'h0;
      #1;
      chk("single_busy", {31'b0, arb_busy}, 32'h1);
      chk("single_rsp_route", {30'b0, m1_icb_rsp_valid, m0_icb_rsp_valid}, 32'h1);
      chk("single_rsp_err", {31'b0, m0_icb_rsp_err}, 32'h0);
      chk("single_sl_rsp_ready", {31'b0, sl_icb_rsp_ready}, 32'h1);
      tick();
      sl_icb_rsp_valid = 1'b0;
      #1;
      chk("single_idle_busy", {31'b0, arb_busy}, 32'h0);

      // ---- outstanding limit: two accepted, third held until after a pop
      m0_icb_cmd_valid = 1'b1;
      m0_icb_cmd_read  = 1'b1;
      #1;
      chk("lim_cmd1_ready", {31'b0, m0_icb_cmd_ready}, 32'h1);
      tick();
      #1;
      chk("lim_cmd2_ready", {31'b0, m0_icb_cmd_ready}, 32'h1);
      tick();
      #1;
      chk("lim_full_ready", {31'b0, m0_icb_cmd_ready}, 32'h0);
      chk("lim_full_sl_valid", {31'b0, sl_icb_cmd_valid}, 32'h0);
      chk("lim_full_busy", {31'b0, arb_busy}, 32'h1);
      tick();
      sl_icb_rsp_valid = 1'b1;
      sl_icb_rsp_rdata = 32'h0000_00B0;
      #1;
      chk("lim_pop_rsp", {30'b0, m1_icb_rsp_valid, m0_icb_rsp_valid}, 32'h1);
      chk("lim_pop_no_bypass", {31'b0, m0_icb_cmd_ready}, 32'h0);
      tick();
      sl_icb_rsp_valid = 1'b0;
      #1;
      chk("lim_cmd3_ready", {31'b0, m0_icb_cmd_ready}, 32'h1);
      tick();
      m0_icb_cmd_valid = 1'b0;
      sl_icb_rsp_valid = 1'b1;
      #1;
      chk("lim_drain1", {30'b0, m1_icb_rsp_valid, m0_icb_rsp_valid}, 32'h1);
      tick();
      #1;
      chk("lim_drain2", {30'b0, m1_icb_rsp_valid, m0_icb_rsp_valid}, 32'h1);
      tick();
      sl_icb_rsp_valid = 1'b0;
      #1;
      chk("lim_idle_busy", {31'b0, arb_busy}, 32'h0);

      // ---- response backpressure with m1 at the head
      m1_icb_cmd_valid = 1'b1;
      #1;
      chk("bp_m1_ready", {30'b0, m1_icb_cmd_ready, m0_icb_cmd_ready}, 32'h2);
      tick();
      m1_icb_cmd_valid = 1'b0;
      m0_icb_cmd_valid = 1'b1;
      #1;
      chk("bp_m0_ready", {30'b0, m1_icb_cmd_ready, m0_icb_cmd_ready}, 32'h1);
      tick();
      m0_icb_cmd_valid = 1'b0;
      sl_icb_rsp_valid = 1'b1;
      m1_icb_rsp_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("bp_sl_rsp_ready", {31'b0, sl_icb_rsp_ready}, 32'h0);
         chk("bp_route", {30'b0, m1_icb_rsp_valid, m0_icb_rsp_valid}, 32'h2);
         tick();
      end
      m1_icb_rsp_ready = 1'b1;
      #1;
      chk("bp_release", {31'b0, sl_icb_rsp_ready}, 32'h1);
      tick();
      #1;
      chk("bp_next_head", {30'b0, m1_icb_rsp_valid, m0_icb_rsp_valid}, 32'h1);
      tick();
      sl_icb_rsp_valid = 1'b0;
      #1;
      chk("bp_idle_busy", {31'b0, arb_busy}, 32'h0);

      // ---- simultaneous push/pop with outs_cnt = 1
      m0_icb_cmd_valid = 1'b1;
      tick();
      m0_icb_cmd_valid = 1'b0;
      m1_icb_cmd_valid = 1'b1;
      sl_icb_rsp_valid = 1'b1;
      #1;
      chk("pp_push_ready", {30'b0, m1_icb_cmd_ready, m0_icb_cmd_ready}, 32'h2);
      chk("pp_pop_route", {30'b0, m1_icb_rsp_valid, m0_icb_rsp_valid}, 32'h1);
      tick();
      m1_icb_cmd_valid = 1'b0;
      #1;
      chk("pp_busy", {31'b0, arb_busy}, 32'h1);
      chk("pp_new_route", {30'b0, m1_icb_rsp_valid, m0_icb_rsp_valid}, 32'h2);
      tick();
      sl_icb_rsp_valid = 1'b0;
      #1;
      chk("pp_idle_busy", {31'b0, arb_busy}, 32'h0);

      // ---- reset with two outstanding and rr_ptr pointing at m1
      m1_icb_cmd_valid = 1'b1;
      tick();
      m1_icb_cmd_valid = 1'b0;
      m0_icb_cmd_valid = 1'b1;
      tick();
      rst              = 1'b1;
      m1_icb_cmd_valid = 1'b1;
      sl_icb_rsp_valid = 1'b1;
      #1;
      chk("mrst_cmd", {29'b0, sl_icb_cmd_valid, m1_icb_cmd_ready, m0_icb_cmd_ready}, 32'h0);
      chk("mrst_rsp", {29'b0, m1_icb_rsp_valid, m0_icb_rsp_valid, sl_icb_rsp_ready}, 32'h0);
      tick();
      rst              = 1'b0;
      sl_icb_rsp_valid = 1'b0;
      #1;
      chk("mrst_busy", {31'b0, arb_busy}, 32'h0);
      chk("mrst_first_grant", {29'b0, sl_icb_cmd_valid, m1_icb_cmd_ready, m0_icb_cmd_ready},
          32'h5);
      tick();
      m0_icb_cmd_valid = 1'b0;
      m1_icb_cmd_valid = 1'b0;
      sl_icb_rsp_valid = 1'b1;
      #1;
      chk("mrst_rsp_route", {30'b0, m1_icb_rsp_valid, m0_icb_rsp_valid}, 32'h1);
      tick();
      sl_icb_rsp_valid = 1'b0;
      #1;
      chk("mrst_idle_busy", {31'b0, arb_busy}, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
